uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4: number of message sources, legal range 2..8.
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 8: cycles to wait for tx_busy to rise after a byte issue.
REQ-003 SHALL have port clk, input, 1: single system clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port src_valid, input, NUM_SRC: per-source message offer; each high cycle is one offer.
REQ-006 SHALL have port src_data, input, NUM_SRC*16: source i first byte at [16i+15:16i+8], second byte at [16i+7:16i].
REQ-007 SHALL have port src_two, input, NUM_SRC: 1 = two-byte message, 0 = first byte only.
REQ-008 SHALL have port src_accept, output, NUM_SRC: one-cycle pulse when mailbox i captures an offer.
REQ-009 SHALL have port src_pending, output, NUM_SRC: mailbox i holds an unsent message.
REQ-010 SHALL have port tx_data, output, 8: byte presented to uart_tx.
REQ-011 SHALL have port tx_valid, output, 1: single-cycle byte strobe to uart_tx.
REQ-012 SHALL have port tx_busy, input, 1: uart_tx busy indication.
REQ-013 SHALL have port drop_count, output, 8: saturating count of refused offers.
REQ-014 SHALL have port active_src, output, 3: index of the source being sent; meaningful only while arb_busy is high.
REQ-015 SHALL have port arb_busy, output, 1: high in every state except IDLE.

Function
REQ-016 SHALL handle offers as follows: src_valid[i] with src_pending[i] low captures src_data/src_two into mailbox i, sets pending, and pulses src_accept[i] the next cycle.
REQ-017 SHALL refuse src_valid[i] while pending[i] is high (as registered at that edge, including the cycle the mailbox is being freed) and increment drop_count, saturating at 255.
REQ-018 SHALL decouple captured bytes from src_data, so sources may change src_data after accept.
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT_RISE, DONE.
REQ-020 In IDLE with any pending, SHALL pick the winner round-robin from rr_ptr upward modulo NUM_SRC, latch it into active_src, clear byte_idx, and go to ISSUE.
REQ-021 In ISSUE with tx_busy low, SHALL drive tx_valid=1 for one cycle with the byte_idx byte, clear the timeout counter, and go to WAIT_RISE; with tx_busy high, SHALL hold in ISSUE with tx_valid low.
REQ-022 In WAIT_RISE, on tx_busy=1 or timeout counter = BUSY_TIMEOUT-1: if src_two and byte_idx=0, SHALL set byte_idx=1 and go to ISSUE; otherwise SHALL go to DONE.
REQ-023 In DONE, SHALL clear pending[active_src], set rr_ptr = active_src+1 modulo NUM_SRC, and go to IDLE.
REQ-024 SHALL make tx_valid registered and high exactly one cycle per byte; tx_data SHALL hold its last value while tx_valid is low.
REQ-025 Latency: with FSM in IDLE and tx_busy low, tx_valid SHALL rise 2 cycles after the accepting edge.
REQ-026 SHALL handle simultaneous offers on several sources in one cycle by accepting all (all not pending) and sending them in round-robin order.
REQ-027 SHALL avoid lockup when tx_busy never rises: the timeout bounds WAIT_RISE to BUSY_TIMEOUT cycles.

Reset
REQ-028 On rst, SHALL asynchronously clear FSM=IDLE, mailboxes, src_pending, src_accept, tx_valid, tx_data, drop_count, rr_ptr, active_src, arb_busy, and byte_idx to 0, abandoning any in-flight message.
REQ-029 SHALL emit no tx_valid after reset release until a new offer is accepted.

Structure
REQ-030 SHALL place the FSM state enum, MSG_W=16, and the drop counter width in shared package uart_tx_arb_pkg.
REQ-031 SHALL implement per-source storage as sub-module uart_tx_mailbox, instantiated NUM_SRC times.

Verification
REQ-032 Two-byte offer on src2 (A1, 7C), tx_busy modelled 10 cycles -> tx_data A1 then 7C, one strobe each, src_pending[2] cleared after second busy rise.
REQ-033 After reset, same-cycle single-byte offers on src0=55, src1=B2, src3=14 -> bytes 55, B2, 14 in order; a fresh src0 offer made during B2 goes after 14.
REQ-034 src1 offered twice while pending -> drop_count=1; 300 refused offers -> drop_count=255.
REQ-035 tx_busy stuck low, two-byte message -> two strobes spaced BUSY_TIMEOUT+1 cycles, then return to IDLE.
REQ-036 tx_busy held high when an offer lands -> tx_valid withheld until tx_busy falls, then strobe on the next cycle.
REQ-037 rst asserted between first and second byte -> all outputs 0 immediately, second byte never sent, no strobe after release.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and widths for the UART transmit arbiter and its mailboxes.
package uart_tx_arb_pkg;
  localparam int MSG_W  = 16;
  localparam int DROP_W = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RISE, DONE} arb_state_e;

  // Adds a wrap at n; both operands are below n, so one subtraction suffices.
  function automatic logic [2:0] wrap_idx(input logic [3:0] idx, input int unsigned n);
    logic [3:0] w;
    w = (idx >= 4'(n)) ? idx - 4'(n) : idx;
    return w[2:0];
  endfunction
endpackage

// File: rtl/uart_tx_mailbox.sv
// One-message holding slot per source: captures an offer when empty, refuses it when full.
module uart_tx_mailbox
  import uart_tx_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic             two_i,
  input  logic [MSG_W-1:0] data_i,
  input  logic             clear_i,
  output logic             pending_o,
  output logic             accept_o,
  output logic             refuse_o,
  output logic             two_o,
  output logic [MSG_W-1:0] data_o
);
  logic             pending_q, accept_q, two_q;
  logic [MSG_W-1:0] data_q;
  logic             capture;

  // An offer landing on the same edge that frees the slot is still refused.
  assign capture  = valid_i & ~pending_q;
  assign refuse_o = valid_i &  pending_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 1'b0;
      accept_q  <= 1'b0;
      two_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      accept_q <= capture;
      if (capture) begin
        pending_q <= 1'b1;
        data_q    <= data_i;
        two_q     <= two_i;
      end else if (clear_i) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign pending_o = pending_q;
  assign accept_o  = accept_q;
  assign two_o     = two_q;
  assign data_o    = data_q;
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one- or two-byte messages from NUM_SRC mailboxes into a uart_tx,
// with a busy-rise timeout so a silent transmitter cannot stall the arbiter.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [NUM_SRC*MSG_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]       src_two,
  output logic [NUM_SRC-1:0]       src_accept,
  output logic [NUM_SRC-1:0]       src_pending,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_busy,
  output logic [DROP_W-1:0]        drop_count,
  output logic [2:0]               active_src,
  output logic                     arb_busy
);
  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  logic [NUM_SRC-1:0][MSG_W-1:0] mb_data;
  logic [NUM_SRC-1:0]            mb_two, mb_refuse, mb_clear;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_mb
    uart_tx_mailbox u_mb (
      .clk       (clk),
      .rst       (rst),
      .valid_i   (src_valid[g]),
      .two_i     (src_two[g]),
      .data_i    (src_data[g*MSG_W +: MSG_W]),
      .clear_i   (mb_clear[g]),
      .pending_o (src_pending[g]),
      .accept_o  (src_accept[g]),
      .refuse_o  (mb_refuse[g]),
      .two_o     (mb_two[g]),
      .data_o    (mb_data[g])
    );
  end

  arb_state_e        state_q, state_d;
  logic [2:0]        active_q, active_d, rr_q, rr_d;
  logic              byte_q, byte_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              txv_q, txv_d;
  logic [7:0]        txd_q, txd_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic [DROP_W:0]   drop_sum;
  logic              found;
  logic [2:0]        pick, cand;
  logic [MSG_W-1:0]  cur_msg;
  logic              cur_two;
  logic [7:0]        cur_byte;

  always_comb begin
    drop_sum = {1'b0, drop_q};
    for (int i = 0; i < NUM_SRC; i++) drop_sum = drop_sum + (DROP_W+1)'(mb_refuse[i]);
    drop_d = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
  end

  // First pending mailbox at or after rr_q, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = wrap_idx({1'b0, rr_q} + 4'(k), NUM_SRC);
      if (!found && src_pending[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) mb_clear[i] = (state_q == DONE) && (active_q == 3'(i));
  end

  assign cur_msg  = mb_data[active_q[IDX_W-1:0]];
  assign cur_two  = mb_two[active_q[IDX_W-1:0]];
  assign cur_byte = byte_q ? cur_msg[7:0] : cur_msg[MSG_W-1:8];

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    byte_d   = byte_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    txv_d    = 1'b0;
    txd_d    = txd_q;
    unique case (state_q)
      IDLE: if (found) begin
        active_d = pick;
        byte_d   = 1'b0;
        state_d  = ISSUE;
      end
      ISSUE: if (!tx_busy) begin
        txv_d   = 1'b1;
        txd_d   = cur_byte;
        cnt_d   = '0;
        state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (tx_busy || cnt_q == CNT_W'(BUSY_TIMEOUT-1)) begin
          if (cur_two && !byte_q) begin
            byte_d  = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        rr_d    = wrap_idx({1'b0, active_q} + 4'd1, NUM_SRC);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      active_q <= '0;
      byte_q   <= 1'b0;
      cnt_q    <= '0;
      rr_q     <= '0;
      txv_q    <= 1'b0;
      txd_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      byte_q   <= byte_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      txv_q    <= txv_d;
      txd_q    <= txd_d;
      drop_q   <= drop_d;
    end
  end

  assign tx_valid   = txv_q;
  assign tx_data    = txd_q;
  assign drop_count = drop_q;
  assign active_src = active_q;
  assign arb_busy   = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter against a message-level reference model.
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int T = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   src_valid = '0, src_two = '0;
  logic [N*16-1:0] src_data = '0;
  logic [N-1:0]   src_accept, src_pending;
  logic [7:0]     tx_data, drop_count;
  logic           tx_valid, arb_busy;
  logic           tx_busy = 1'b0;
  logic [2:0]     active_src;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_SRC(N), .BUSY_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_data(src_data), .src_two(src_two),
    .src_accept(src_accept), .src_pending(src_pending), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_busy(tx_busy), .drop_count(drop_count), .active_src(active_src), .arb_busy(arb_busy)
  );

  int errs = 0, nchk = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // uart_tx stand-in: 0 = busy for blen cycles after each strobe, 1 = stuck low,
  // 2 = random, 3 = stuck high.
  int bmode = 0, blen = 10, bcnt = 0;
  always @(posedge clk) begin
    #1;
    case (bmode)
      0: begin
        if (tx_valid) bcnt = blen;
        tx_busy = (bcnt > 0);
        if (bcnt > 0) bcnt--;
      end
      1: tx_busy = 1'b0;
      2: tx_busy = ($urandom_range(0, 3) == 0);
      default: tx_busy = 1'b1;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Reference: mailboxes plus one message in flight, described as a queue of bytes still to go.
  logic [N-1:0] m_pend, m_acc, oldp;
  logic [15:0]  m_msg [N];
  logic [N-1:0] m_two;
  int           m_drop, refused, m_rr, m_act, serving, waited;
  logic         m_txv;
  logic [7:0]   m_txd;
  bit           ready, closing;
  logic [7:0]   pq [$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend = '0; m_acc = '0; m_two = '0; m_drop = 0; m_rr = 0; m_act = 0;
      for (int i = 0; i < N; i++) m_msg[i] = '0;
      m_txv = 1'b0; m_txd = '0; serving = -1; waited = 0; ready = 0; closing = 0;
      pq.delete();
    end else begin
      oldp = m_pend;
      m_txv = 1'b0;
      refused = 0;
      for (int i = 0; i < N; i++) begin
        m_acc[i] = src_valid[i] && !oldp[i];
        if (src_valid[i] && oldp[i]) refused++;
        if (m_acc[i]) begin
          m_pend[i] = 1'b1;
          m_msg[i]  = src_data[i*16 +: 16];
          m_two[i]  = src_two[i];
        end
      end
      m_drop = (m_drop + refused > 255) ? 255 : m_drop + refused;
      if (serving < 0) begin
        for (int k = 0; k < N; k++)
          if (serving < 0 && oldp[(m_rr + k) % N]) serving = (m_rr + k) % N;
        if (serving >= 0) begin
          m_act = serving;
          pq.delete();
          pq.push_back(m_msg[serving][15:8]);
          if (m_two[serving]) pq.push_back(m_msg[serving][7:0]);
          ready = 1; closing = 0;
        end
      end else if (closing) begin
        m_pend[serving] = 1'b0;
        m_rr = (serving + 1) % N;
        serving = -1;
        closing = 0;
      end else if (ready) begin
        if (!tx_busy) begin
          m_txv = 1'b1;
          m_txd = pq.pop_front();
          ready = 0;
          waited = 0;
        end
      end else if (tx_busy || waited == T - 1) begin
        if (pq.size() > 0) ready = 1;
        else closing = 1;
      end else begin
        waited++;
      end
    end
  end

  logic [7:0] logb [$];
  int         logc [$];

  task automatic cmp_all();
    chk("tx_valid",    32'(tx_valid),    32'(m_txv));
    chk("tx_data",     32'(tx_data),     32'(m_txd));
    chk("src_accept",  32'(src_accept),  32'(m_acc));
    chk("src_pending", 32'(src_pending), 32'(m_pend));
    chk("drop_count",  32'(drop_count),  32'(m_drop));
    chk("arb_busy",    32'(arb_busy),    32'(serving >= 0));
    chk("active_src",  32'(active_src),  32'(m_act));
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_all();
    if (tx_valid) begin
      logb.push_back(tx_data);
      logc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    src_valid = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_valid = '0;
    #1;
    chk("rst_tx_valid", 32'(tx_valid),    32'd0);
    chk("rst_tx_data",  32'(tx_data),     32'd0);
    chk("rst_pending",  32'(src_pending), 32'd0);
    chk("rst_arb_busy", 32'(arb_busy),    32'd0);
    chk("rst_drop",     32'(drop_count),  32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic offer(input int s, input logic [15:0] d, input logic two);
    src_valid[s]        = 1'b1;
    src_data[s*16 +: 16] = d;
    src_two[s]          = two;
  endtask

  task automatic wait_log(input int n, input int budget);
    for (int i = 0; i < budget && logb.size() < n; i++) tick();
    chk("wait_log", 32'(logb.size()), 32'(n));
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && arb_busy; i++) tick();
    chk("idle", 32'(arb_busy), 32'd0);
  endtask

  int c0;

  initial begin
    #2;
    do_reset();
    tick();

    // Two-byte message on src2 with a 10-cycle transmitter.
    bmode = 0; blen = 10;
    logb.delete(); logc.delete();
    offer(2, 16'hA17C, 1'b1);
    tick();
    wait_log(2, 80);
    wait_idle(60);
    if (logb.size() == 2) begin
      chk("s2_byte0", 32'(logb[0]), 32'hA1);
      chk("s2_byte1", 32'(logb[1]), 32'h7C);
    end
    chk("s2_pending", 32'(src_pending), 32'd0);

    // Same-cycle offers, then a fresh src0 offer while B2 is going out.
    do_reset();
    blen = 3;
    logb.delete(); logc.delete();
    offer(0, 16'h55E1, 1'b0);
    offer(1, 16'hB2E2, 1'b0);
    offer(3, 16'h14E3, 1'b0);
    tick();
    wait_log(2, 80);
    offer(0, 16'h6699, 1'b0);
    tick();
    wait_log(4, 120);
    wait_idle(60);
    if (logb.size() == 4) begin
      chk("rr_0", 32'(logb[0]), 32'h55);
      chk("rr_1", 32'(logb[1]), 32'hB2);
      chk("rr_2", 32'(logb[2]), 32'h14);
      chk("rr_3", 32'(logb[3]), 32'h66);
    end

    // Refused offers and drop counter saturation, with the transmitter held busy.
    do_reset();
    #2 bmode = 3;
    tick();
    offer(1, 16'h1111, 1'b0); tick();
    offer(1, 16'h2222, 1'b0); tick();
    tick();
    chk("drop_one", 32'(drop_count), 32'd1);
    for (int i = 0; i < 300; i++) begin
      offer(1, 16'h3333, 1'b0);
      tick();
    end
    tick();
    chk("drop_sat", 32'(drop_count), 32'd255);
    bmode = 0; blen = 2;
    wait_idle(80);

    // Transmitter never raises busy: timeout paces the two strobes.
    do_reset();
    bmode = 1;
    logb.delete(); logc.delete();
    offer(0, 16'hC33C, 1'b1);
    tick();
    wait_log(2, 60);
    if (logc.size() == 2) chk("timeout_gap", 32'(logc[1] - logc[0]), 32'(T + 1));
    wait_idle(40);

    // Busy held high when the offer lands; strobe follows the fall by one cycle.
    do_reset();
    #2 bmode = 3;
    tick(); tick();
    logb.delete(); logc.delete();
    offer(3, 16'h5A00, 1'b0);
    repeat (6) tick();
    chk("held_no_strobe", 32'(logb.size()), 32'd0);
    #2 bmode = 0; blen = 3;
    tick();
    c0 = cyc;
    wait_log(1, 20);
    if (logc.size() == 1) chk("fall_to_strobe", 32'(logc[0]), 32'(c0 + 1));
    wait_idle(40);

    // Reset between the two bytes of a message.
    do_reset();
    blen = 4;
    logb.delete(); logc.delete();
    offer(1, 16'h9E61, 1'b1);
    tick();
    wait_log(1, 20);
    tick(); tick();
    do_reset();
    logb.delete(); logc.delete();
    repeat (30) tick();
    chk("no_strobe_after_rst", 32'(logb.size()), 32'd0);

    // Random traffic against the model.
    bmode = 2;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < N; i++) begin
        src_valid[i]        = ($urandom_range(0, 2) == 0);
        src_data[i*16 +: 16] = 16'($urandom());
        src_two[i]          = 1'($urandom());
      end
      tick();
    end
    bmode = 0; blen = 2;
    wait_idle(200);
    repeat (40) tick();

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
